ibex_instr_aligner: RTL



---
 rtl/ibex_instr_aligner_pkg.sv | 24 ++
 rtl/ibex_instr_aligner.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ibex_instr_aligner_pkg.sv
// Shared types and helpers for the instruction aligner and the ID-stage register.
package ibex_instr_aligner_pkg;

  localparam logic [1:0] OPCODE_UNCOMP = 2'b11;

  typedef enum logic [1:0] {
    ST_A,  // no hold, PC on lower halfword
    ST_B,  // no hold, PC on upper halfword
    ST_C   // lower half of a spanning instruction held
  } align_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        compressed;
    logic        err;
    logic        err_plus2;
  } aligner_out_t;

  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != OPCODE_UNCOMP;
  endfunction

endpackage

// File: rtl/ibex_instr_aligner.sv
// Realigns word-aligned fetch data into whole 16/32-bit instructions,
// carrying the PC and per-half error attribution across spanning fetches.
module ibex_instr_aligner
  import ibex_instr_aligner_pkg::*;
#(
  parameter bit          ResetAll = 1'b0,
  parameter logic [31:0] BootAddr = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        out_compressed_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o,
  output logic        busy_o
);

  logic [31:0]  r_pc;
  logic         r_hold_valid;
  logic [15:0]  r_hold_instr;
  logic         r_hold_err;

  align_state_e w_state;
  aligner_out_t w_out;
  logic [15:0]  w_lo;
  logic [15:0]  w_hi;
  logic         w_valid;
  logic         w_consume;
  logic         w_capture;
  logic         w_inc4;
  logic         w_hs;
  logic         w_ready;

  assign w_lo = in_rdata_i[15:0];
  assign w_hi = in_rdata_i[31:16];

  always_comb begin
    if (r_hold_valid)    w_state = ST_C;
    else if (r_pc[1])    w_state = ST_B;
    else                 w_state = ST_A;
  end

  always_comb begin
    w_out            = '0;
    w_out.instr      = in_rdata_i;
    w_out.addr       = r_pc;
    w_valid          = 1'b0;
    w_consume        = 1'b0;
    w_capture        = 1'b0;
    w_inc4           = 1'b0;
    unique case (w_state)
      ST_A: begin
        w_valid = in_valid_i;
        if (in_err_i) begin
          w_out.err = 1'b1;
          w_consume = 1'b1;
          w_inc4    = 1'b1;
        end else if (is_compressed(w_lo)) begin
          w_out.instr      = {16'h0000, w_lo};
          w_out.compressed = 1'b1;
        end else begin
          w_consume = 1'b1;
          w_inc4    = 1'b1;
        end
      end
      ST_B: begin
        if (in_err_i) begin
          w_valid   = in_valid_i;
          w_out.err = 1'b1;
          w_consume = 1'b1;
        end else if (is_compressed(w_hi)) begin
          w_valid          = in_valid_i;
          w_out.instr      = {16'h0000, w_hi};
          w_out.compressed = 1'b1;
          w_consume        = 1'b1;
        end else begin
          w_capture = in_valid_i;
        end
      end
      default: begin
        w_valid         = in_valid_i;
        w_out.instr     = {w_lo, r_hold_instr};
        w_out.err       = r_hold_err | in_err_i;
        w_out.err_plus2 = in_err_i & ~r_hold_err;
        w_inc4          = 1'b1;
      end
    endcase
  end

  // A branch suppresses both handshakes; capture needs no downstream accept.
  assign w_hs    = w_valid & out_ready_i & ~branch_i;
  assign w_ready = ((w_consume & w_hs) | w_capture) & ~branch_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc         <= BootAddr;
      r_hold_valid <= 1'b0;
      r_hold_err   <= 1'b0;
    end else if (branch_i) begin
      r_pc         <= {addr_i[31:1], 1'b0};
      r_hold_valid <= 1'b0;
      r_hold_err   <= 1'b0;
    end else if (w_hs) begin
      r_pc <= r_pc + (w_inc4 ? 32'd4 : 32'd2);
      if (w_state == ST_C) r_hold_valid <= 1'b0;
    end else if (w_capture) begin
      r_hold_valid <= 1'b1;
      r_hold_err   <= 1'b0;
    end
  end

  if (ResetAll) begin : g_hold_rst
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                        r_hold_instr <= '0;
      else if (!branch_i && w_capture)  r_hold_instr <= w_hi;
    end
  end else begin : g_hold_norst
    always_ff @(posedge clk_i) begin
      if (!branch_i && w_capture) r_hold_instr <= w_hi;
    end
  end

  assign in_ready_o       = rst_i ? 1'b0 : w_ready;
  assign out_valid_o      = rst_i ? 1'b0 : (w_valid & ~branch_i);
  assign out_instr_o      = rst_i ? '0   : w_out.instr;
  assign out_addr_o       = rst_i ? BootAddr : w_out.addr;
  assign out_compressed_o = rst_i ? 1'b0 : w_out.compressed;
  assign out_err_o        = rst_i ? 1'b0 : w_out.err;
  assign out_err_plus2_o  = rst_i ? 1'b0 : w_out.err_plus2;
  assign busy_o           = rst_i ? 1'b0 : r_hold_valid;

endmodule
